// File: rtl/bp_pkg.sv
// Shared definitions for the dynamic branch predictor: counter constants and
// PC field extraction helpers used by the predictor and its sub-modules.
package bp_pkg;

    function automatic int unsigned CTR_MAX(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

    // Weakly-taken value: only the MSB set, so a single not-taken step flips it.
    function automatic int unsigned CTR_WEAK_T(input int unsigned w);
        return 32'd1 << (w - 32'd1);
    endfunction

    function automatic int unsigned CTR_ZERO(input int unsigned w);
        return CTR_MAX(w) & 32'd0;
    endfunction

    function automatic logic [63:0] bp_index(input logic [63:0] pc, input int unsigned idx_w);
        return (pc >> 2) & ((64'd1 << idx_w) - 64'd1);
    endfunction

    function automatic logic [63:0] bp_tag(input logic [63:0] pc, input int unsigned idx_w);
        return pc >> (idx_w + 32'd2);
    endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Next-state logic for a CTR_W-bit saturating prediction counter, shared by
// the table predictor and any future predictor that needs the same policy.
module bp_sat_counter
    import bp_pkg::*;
#(
    parameter int CTR_W = 2
) (
    input  logic [CTR_W-1:0] i_ctr,
    input  logic             i_taken,
    input  logic             i_isJump,
    input  logic             i_alloc,
    output logic [CTR_W-1:0] o_ctrNext
);

    localparam logic [CTR_W-1:0] L_MAX    = CTR_W'(CTR_MAX(CTR_W));
    localparam logic [CTR_W-1:0] L_WEAK_T = CTR_W'(CTR_WEAK_T(CTR_W));
    localparam logic [CTR_W-1:0] L_ZERO   = CTR_W'(CTR_ZERO(CTR_W));

    // Jumps always pin the counter high; fresh branches start weakly taken.
    always_comb begin
        o_ctrNext = i_ctr;
        if (i_alloc) begin
            o_ctrNext = i_isJump ? L_MAX : L_WEAK_T;
        end else if (i_isJump) begin
            o_ctrNext = L_MAX;
        end else if (i_taken) begin
            if (i_ctr != L_MAX) begin
                o_ctrNext = i_ctr + CTR_W'(1);
            end
        end else begin
            if (i_ctr != L_ZERO) begin
                o_ctrNext = i_ctr - CTR_W'(1);
            end
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped dynamic branch predictor: combinational IF-stage lookup and
// single-cycle update from ID-stage branch/jump resolution.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int ADDR_W  = 32,
    parameter int CTR_W   = 2
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [ADDR_W-1:0]           lookup_pc,
    output logic                        pred_taken,
    output logic [ADDR_W-1:0]           pred_next_pc,
    input  logic                        upd_valid,
    input  logic [ADDR_W-1:0]           upd_pc,
    input  logic                        upd_taken,
    input  logic                        upd_is_jump,
    input  logic [ADDR_W-1:0]           upd_target,
    input  logic                        inv_all,
    output logic [$clog2(ENTRIES):0]    valid_count
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [ADDR_W-1:0] target;
        logic [CTR_W-1:0]  ctr;
    } entry_t;

    entry_t            r_table [ENTRIES];
    logic [IDX_W:0]    r_validCount;

    logic [IDX_W-1:0]  w_lookupIdx;
    logic [TAG_W-1:0]  w_lookupTag;
    entry_t            w_lookupEntry;
    logic              w_lookupHit;

    logic [IDX_W-1:0]  w_updIdx;
    logic [TAG_W-1:0]  w_updTag;
    entry_t            w_updEntry;
    entry_t            w_newEntry;
    logic              w_updHit;
    logic              w_updTaken;
    logic              w_alloc;
    logic              w_wrEn;
    logic [CTR_W-1:0]  w_ctrNext;

    assign w_lookupIdx   = IDX_W'(bp_index(64'(lookup_pc), IDX_W));
    assign w_lookupTag   = TAG_W'(bp_tag(64'(lookup_pc), IDX_W));
    assign w_lookupEntry = r_table[w_lookupIdx];
    assign w_lookupHit   = w_lookupEntry.valid && (w_lookupEntry.tag == w_lookupTag);

    assign pred_taken    = w_lookupHit && w_lookupEntry.ctr[CTR_W-1];
    assign pred_next_pc  = pred_taken ? w_lookupEntry.target : lookup_pc + ADDR_W'(4);
    assign valid_count   = r_validCount;

    // An illegal jump-not-taken is folded into "taken" so jumps always allocate.
    assign w_updIdx   = IDX_W'(bp_index(64'(upd_pc), IDX_W));
    assign w_updTag   = TAG_W'(bp_tag(64'(upd_pc), IDX_W));
    assign w_updEntry = r_table[w_updIdx];
    assign w_updHit   = w_updEntry.valid && (w_updEntry.tag == w_updTag);
    assign w_updTaken = upd_taken || upd_is_jump;
    assign w_alloc    = !w_updHit && w_updTaken;
    assign w_wrEn     = upd_valid && (w_updHit || w_updTaken);

    bp_sat_counter #(
        .CTR_W (CTR_W)
    ) u_satCounter (
        .i_ctr     (w_updEntry.ctr),
        .i_taken   (w_updTaken),
        .i_isJump  (upd_is_jump),
        .i_alloc   (w_alloc),
        .o_ctrNext (w_ctrNext)
    );

    always_comb begin
        w_newEntry        = w_updEntry;
        w_newEntry.valid  = 1'b1;
        w_newEntry.tag    = w_updTag;
        w_newEntry.ctr    = w_ctrNext;
        if (w_updTaken) begin
            w_newEntry.target = upd_target;
        end
    end

    // Reset and invalidate share one path; a concurrent update is dropped.
    always_ff @(posedge clock) begin
        if (reset || inv_all) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_table[i] <= '0;
            end
            r_validCount <= '0;
        end else if (w_wrEn) begin
            r_table[w_updIdx] <= w_newEntry;
            if (w_alloc && !w_updEntry.valid) begin
                r_validCount <= r_validCount + (IDX_W + 1)'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor using a 4-entry table so
// that index aliasing is easy to provoke with hand-picked PCs.
module tb_branch_predictor;

    localparam int ENTRIES = 4;
    localparam int ADDR_W  = 32;
    localparam int CTR_W   = 2;

    logic              clock = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] lookupPc;
    logic              predTaken;
    logic [ADDR_W-1:0] predNextPc;
    logic              updValid;
    logic [ADDR_W-1:0] updPc;
    logic              updTaken;
    logic              updIsJump;
    logic [ADDR_W-1:0] updTarget;
    logic              invAll;
    logic [2:0]        validCount;

    int vecCount  = 0;
    int missCount = 0;

    branch_predictor #(
        .ENTRIES (ENTRIES),
        .ADDR_W  (ADDR_W),
        .CTR_W   (CTR_W)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .lookup_pc    (lookupPc),
        .pred_taken   (predTaken),
        .pred_next_pc (predNextPc),
        .upd_valid    (updValid),
        .upd_pc       (updPc),
        .upd_taken    (updTaken),
        .upd_is_jump  (updIsJump),
        .upd_target   (updTarget),
        .inv_all      (invAll),
        .valid_count  (validCount)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (updValid && updIsJump && !updTaken) begin
            $error("[TB] illegal jump-not-taken update driven");
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_upd(input logic t, input logic j, input logic [31:0] pc, input logic [31:0] tgt);
        updValid  = 1'b1;
        updTaken  = t;
        updIsJump = j;
        updPc     = pc;
        updTarget = tgt;
    endtask

    task automatic drive_idle();
        updValid  = 1'b0;
        updTaken  = 1'b0;
        updIsJump = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; invAll = 1'b0; lookupPc = 32'h0; updPc = 32'h0; updTarget = 32'h0;
        drive_idle();
        step();
        step();
        reset = 1'b0;
        lookupPc = 32'h0040_0010;
        #1;
        vecCount++;
        if (predTaken !== 1'b0) begin missCount++; $display("[TB] FAIL reset_taken: got %b want 0", predTaken); end
        vecCount++;
        if (predNextPc !== 32'h0040_0014) begin missCount++; $display("[TB] FAIL reset_next: got %h want 00400014", predNextPc); end
        vecCount++;
        if (validCount !== 3'd0) begin missCount++; $display("[TB] FAIL reset_count: got %0d want 0", validCount); end
    endtask

    task automatic test_alloc();
        lookupPc = 32'h0040_0008;
        drive_upd(1'b1, 1'b0, 32'h0040_0008, 32'h0040_0100);
        #1;
        vecCount++;
        if (predTaken !== 1'b0 || predNextPc !== 32'h0040_000C) begin
            missCount++; $display("[TB] FAIL no_bypass: got %b/%h want 0/0040000c", predTaken, predNextPc);
        end
        step();
        drive_idle();
        #1;
        vecCount++;
        if (predTaken !== 1'b1 || predNextPc !== 32'h0040_0100) begin
            missCount++; $display("[TB] FAIL alloc_pred: got %b/%h want 1/00400100", predTaken, predNextPc);
        end
        vecCount++;
        if (validCount !== 3'd1) begin missCount++; $display("[TB] FAIL alloc_count: got %0d want 1", validCount); end
    endtask

    task automatic test_counter();
        // Counter 2 -> 1 -> 0 -> 0 (saturated low); target must not move on not-taken
        logic [3:0] expTaken = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            drive_upd(1'b0, 1'b0, 32'h0040_0008, 32'h0DEA_D000);
            step();
            drive_idle();
            #1;
            vecCount++;
            if (predTaken !== 1'b0 || predNextPc !== 32'h0040_000C) begin
                missCount++; $display("[TB] FAIL ctr_down%0d: got %b/%h want 0/0040000c", i, predTaken, predNextPc);
            end
        end
        // Four taken: 0 -> 1 -> 2 -> 3 -> 3; last one moves the target
        expTaken = 4'b1110;
        for (int i = 0; i < 4; i++) begin
            drive_upd(1'b1, 1'b0, 32'h0040_0008, (i == 3) ? 32'h0040_0200 : 32'h0040_0100);
            step();
            drive_idle();
            #1;
            vecCount++;
            if (predTaken !== expTaken[i]) begin
                missCount++; $display("[TB] FAIL ctr_up%0d: got %b want %b", i, predTaken, expTaken[i]);
            end
        end
        vecCount++;
        if (predNextPc !== 32'h0040_0200) begin missCount++; $display("[TB] FAIL target_upd: got %h want 00400200", predNextPc); end
        // From saturated 3: one not-taken stays taken with the old target, the next drops it
        drive_upd(1'b0, 1'b0, 32'h0040_0008, 32'h0DEA_D000);
        step();
        drive_idle();
        #1;
        vecCount++;
        if (predTaken !== 1'b1 || predNextPc !== 32'h0040_0200) begin
            missCount++; $display("[TB] FAIL ctr_sat_hi: got %b/%h want 1/00400200", predTaken, predNextPc);
        end
        drive_upd(1'b0, 1'b0, 32'h0040_0008, 32'h0DEA_D000);
        step();
        drive_idle();
        #1;
        vecCount++;
        if (predTaken !== 1'b0) begin missCount++; $display("[TB] FAIL ctr_back_to_1: got %b want 0", predTaken); end
    endtask

    task automatic test_alias();
        drive_upd(1'b1, 1'b0, 32'h0040_0018, 32'h0040_0300);
        step();
        drive_idle();
        lookupPc = 32'h0040_0008;
        #1;
        vecCount++;
        if (validCount !== 3'd1) begin missCount++; $display("[TB] FAIL alias_count: got %0d want 1", validCount); end
        vecCount++;
        if (predTaken !== 1'b0 || predNextPc !== 32'h0040_000C) begin
            missCount++; $display("[TB] FAIL alias_old: got %b/%h want 0/0040000c", predTaken, predNextPc);
        end
        lookupPc = 32'h0040_0018;
        #1;
        vecCount++;
        if (predTaken !== 1'b1 || predNextPc !== 32'h0040_0300) begin
            missCount++; $display("[TB] FAIL alias_new: got %b/%h want 1/00400300", predTaken, predNextPc);
        end
        // Not-taken miss must not allocate
        drive_upd(1'b0, 1'b0, 32'h0040_0004, 32'h0040_0700);
        step();
        drive_idle();
        lookupPc = 32'h0040_0004;
        #1;
        vecCount++;
        if (validCount !== 3'd1 || predTaken !== 1'b0) begin
            missCount++; $display("[TB] FAIL nt_miss: got cnt %0d taken %b want 1/0", validCount, predTaken);
        end
    endtask

    task automatic test_jump();
        drive_upd(1'b1, 1'b1, 32'h0040_0020, 32'h0040_1000);
        step();
        drive_idle();
        lookupPc = 32'h0040_0020;
        #1;
        vecCount++;
        if (predTaken !== 1'b1 || predNextPc !== 32'h0040_1000 || validCount !== 3'd2) begin
            missCount++; $display("[TB] FAIL jump_alloc: got %b/%h/%0d want 1/00401000/2", predTaken, predNextPc, validCount);
        end
        drive_upd(1'b0, 1'b0, 32'h0040_0020, 32'h0);
        step();
        drive_idle();
        #1;
        vecCount++;
        if (predTaken !== 1'b1) begin missCount++; $display("[TB] FAIL jump_ctr2: got %b want 1", predTaken); end
        drive_upd(1'b0, 1'b0, 32'h0040_0020, 32'h0);
        step();
        drive_idle();
        #1;
        vecCount++;
        if (predTaken !== 1'b0) begin missCount++; $display("[TB] FAIL jump_ctr1: got %b want 0", predTaken); end
        // Jump hit on a weak entry forces it straight back to max with the new target
        drive_upd(1'b1, 1'b1, 32'h0040_0020, 32'h0040_2000);
        step();
        drive_upd(1'b0, 1'b0, 32'h0040_0020, 32'h0);
        step();
        drive_idle();
        #1;
        vecCount++;
        if (predTaken !== 1'b1 || predNextPc !== 32'h0040_2000) begin
            missCount++; $display("[TB] FAIL jump_hit: got %b/%h want 1/00402000", predTaken, predNextPc);
        end
        drive_upd(1'b1, 1'b0, 32'h0040_0004, 32'h0040_0500);
        step();
        drive_idle();
        lookupPc = 32'hFFFF_FFFC;
        #1;
        vecCount++;
        if (validCount !== 3'd3) begin missCount++; $display("[TB] FAIL third_alloc: got %0d want 3", validCount); end
        vecCount++;
        if (predTaken !== 1'b0 || predNextPc !== 32'h0000_0000) begin
            missCount++; $display("[TB] FAIL pc_wrap: got %b/%h want 0/00000000", predTaken, predNextPc);
        end
    endtask

    task automatic test_inv_all();
        logic [31:0] pcs [4];
        pcs[0] = 32'h0040_0018; pcs[1] = 32'h0040_0020; pcs[2] = 32'h0040_0004; pcs[3] = 32'h0040_000C;
        invAll = 1'b1;
        drive_upd(1'b1, 1'b0, 32'h0040_000C, 32'h0040_0600);
        step();
        invAll = 1'b0;
        drive_idle();
        #1;
        vecCount++;
        if (validCount !== 3'd0) begin missCount++; $display("[TB] FAIL inv_count: got %0d want 0", validCount); end
        for (int i = 0; i < 4; i++) begin
            lookupPc = pcs[i];
            #1;
            vecCount++;
            if (predTaken !== 1'b0 || predNextPc !== pcs[i] + 32'd4) begin
                missCount++; $display("[TB] FAIL inv_lookup%0d: got %b/%h want 0/%h", i, predTaken, predNextPc, pcs[i] + 32'd4);
            end
        end
    endtask

    task automatic test_reset_with_update();
        drive_upd(1'b1, 1'b0, 32'h0040_0008, 32'h0040_0100);
        step();
        reset = 1'b1;
        drive_upd(1'b1, 1'b1, 32'h0040_0010, 32'h0040_0800);
        step();
        reset = 1'b0;
        drive_idle();
        lookupPc = 32'h0040_0008;
        #1;
        vecCount++;
        if (validCount !== 3'd0 || predTaken !== 1'b0) begin
            missCount++; $display("[TB] FAIL rst_upd_old: got cnt %0d taken %b want 0/0", validCount, predTaken);
        end
        lookupPc = 32'h0040_0010;
        #1;
        vecCount++;
        if (predTaken !== 1'b0 || predNextPc !== 32'h0040_0014) begin
            missCount++; $display("[TB] FAIL rst_upd_drop: got %b/%h want 0/00400014", predTaken, predNextPc);
        end
    endtask

    initial begin
        test_reset();
        test_alloc();
        test_counter();
        test_alias();
        test_jump();
        test_inv_all();
        test_reset_with_update();
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
